// File: rtl/c_frag_pkg.sv
// rtl/c_frag_pkg.sv - shared mode/state types and the half-mux function for c_frag_array
package c_frag_pkg;

    typedef enum logic {
        SINGLE = 1'b0,
        SPLIT  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    // AB picks the A or B pair, SL picks the member within the pair
    function automatic logic c_frag_half(
        input logic ab,
        input logic sl,
        input logic a1,
        input logic a2,
        input logic b1,
        input logic b2
    );
        return ab ? (sl ? b2 : b1) : (sl ? a2 : a1);
    endfunction

endpackage

// File: rtl/c_frag_lane.sv
// rtl/c_frag_lane.sv - one fragment channel; output register present when C_FRAG_ARRAY_OREG_EN is defined
module c_frag_lane
    import c_frag_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  mode_e mode,
    input  logic  freeze,
    input  logic  en,
    input  logic  tbs,
    input  logic  tab,
    input  logic  tsl,
    input  logic  ta1,
    input  logic  ta2,
    input  logic  tb1,
    input  logic  tb2,
    input  logic  bab,
    input  logic  bsl,
    input  logic  ba1,
    input  logic  ba2,
    input  logic  bb1,
    input  logic  bb2,
    output logic  tz,
    output logic  cz
);

    logic th;
    logic bh;
    logic tz_d;
    logic cz_d;

    always_comb begin
        th   = c_frag_half(tab, tsl, ta1, ta2, tb1, tb2);
        bh   = c_frag_half(bab, bsl, ba1, ba2, bb1, bb2);
        tz_d = th;
        // SPLIT hands the carry output to the bottom half outright; SINGLE lets tbs choose
        if (mode == SPLIT) begin
            cz_d = bh;
        end else begin
            cz_d = tbs ? bh : th;
        end
    end

`ifdef C_FRAG_ARRAY_OREG_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tz <= 1'b0;
            cz <= 1'b0;
        end else if (en && !freeze) begin
            tz <= tz_d;
            cz <= cz_d;
        end
    end
`else
    logic lane_unused;
    assign lane_unused = &{1'b0, clk, resetn, en, freeze};
    assign tz = tz_d;
    assign cz = cz_d;
`endif

endmodule

// File: rtl/c_frag_array.sv
// rtl/c_frag_array.sv - NCH reconfigurable logic fragments with mode-update FSM; C_FRAG_ARRAY_OREG_EN adds output registers
module c_frag_array
    import c_frag_pkg::*;
#(
    parameter int   NCH          = 4,
    parameter logic DEFAULT_MODE = 1'b0,
    parameter int   IDXW         = 4
) (
    input  logic            QCK,
    input  logic            QRN,
    input  logic [NCH-1:0]  TBS,
    input  logic [NCH-1:0]  TAB,
    input  logic [NCH-1:0]  TSL,
    input  logic [NCH-1:0]  TA1,
    input  logic [NCH-1:0]  TA2,
    input  logic [NCH-1:0]  TB1,
    input  logic [NCH-1:0]  TB2,
    input  logic [NCH-1:0]  BAB,
    input  logic [NCH-1:0]  BSL,
    input  logic [NCH-1:0]  BA1,
    input  logic [NCH-1:0]  BA2,
    input  logic [NCH-1:0]  BB1,
    input  logic [NCH-1:0]  BB2,
    input  logic            QEN,
    input  logic            CFG_VLD,
    input  logic [IDXW-1:0] CFG_IDX,
    input  logic            CFG_MODE,
    output logic            CFG_RDY,
    output logic            CFG_DONE,
    output logic            CFG_ERR,
    output logic [NCH-1:0]  MODE,
    output logic [NCH-1:0]  TZ,
    output logic [NCH-1:0]  CZ
);

    localparam logic [IDXW:0] NCH_W = (IDXW + 1)'(NCH);

    cfg_state_e      state;
    cfg_state_e      state_next;
    logic [IDXW-1:0] lat_idx;
    logic            lat_mode;
    logic            idx_ok;
    logic            accept;
    logic            rdy_d;
    logic            done_d;
    logic            commit_wr;
    logic            err_set;
    logic [NCH-1:0]  mode_q;
    logic [NCH-1:0]  freeze;

    assign idx_ok = ({1'b0, lat_idx} < NCH_W);
    assign accept = CFG_VLD & CFG_RDY;

    always_ff @(posedge QCK) begin
        if (!QRN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = HOLD;
            HOLD:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rdy_d     = (state_next == IDLE);
        done_d    = (state == COMMIT);
        commit_wr = (state == COMMIT) && idx_ok;
        err_set   = (state == COMMIT) && !idx_ok;
    end

    // A reset during HOLD/COMMIT lands here before commit_wr can take effect
    always_ff @(posedge QCK) begin
        if (!QRN) begin
            CFG_RDY  <= 1'b0;
            CFG_DONE <= 1'b0;
            CFG_ERR  <= 1'b0;
            mode_q   <= {NCH{DEFAULT_MODE}};
            lat_idx  <= '0;
            lat_mode <= 1'b0;
        end else begin
            CFG_RDY  <= rdy_d;
            CFG_DONE <= done_d;
            if (err_set) begin
                CFG_ERR <= 1'b1;
            end
            if ((state == IDLE) && accept) begin
                lat_idx  <= CFG_IDX;
                lat_mode <= CFG_MODE;
            end
            if (commit_wr) begin
                for (int i = 0; i < NCH; i++) begin
                    if (lat_idx == IDXW'(i)) begin
                        mode_q[i] <= lat_mode;
                    end
                end
            end
        end
    end

    always_comb begin
        freeze = '0;
        for (int i = 0; i < NCH; i++) begin
            freeze[i] = (state != IDLE) && (lat_idx == IDXW'(i));
        end
    end

    assign MODE = mode_q;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        c_frag_lane u_lane (
            .clk    (QCK),
            .resetn (QRN),
            .mode   (mode_e'(mode_q[g])),
            .freeze (freeze[g]),
            .en     (QEN),
            .tbs    (TBS[g]),
            .tab    (TAB[g]),
            .tsl    (TSL[g]),
            .ta1    (TA1[g]),
            .ta2    (TA2[g]),
            .tb1    (TB1[g]),
            .tb2    (TB2[g]),
            .bab    (BAB[g]),
            .bsl    (BSL[g]),
            .ba1    (BA1[g]),
            .ba2    (BA2[g]),
            .bb1    (BB1[g]),
            .bb2    (BB2[g]),
            .tz     (TZ[g]),
            .cz     (CZ[g])
        );
    end

endmodule

// File: tb/tb_c_frag_array.sv
// tb/tb_c_frag_array.sv - table-driven and sequence checks for c_frag_array
module tb_c_frag_array;

    localparam int NCH  = 4;
    localparam int IDXW = 4;
`ifdef C_FRAG_ARRAY_OREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam bit REG = (LAT == 1);

    logic            QCK = 1'b0;
    logic            QRN;
    logic [NCH-1:0]  TBS, TAB, TSL, TA1, TA2, TB1, TB2;
    logic [NCH-1:0]  BAB, BSL, BA1, BA2, BB1, BB2;
    logic            QEN;
    logic            CFG_VLD;
    logic [IDXW-1:0] CFG_IDX;
    logic            CFG_MODE;
    logic            CFG_RDY, CFG_DONE, CFG_ERR;
    logic [NCH-1:0]  MODE, TZ, CZ;

    // index: 0 tbs, 1 tab, 2 tsl, 3 ta1, 4 ta2, 5 tb1, 6 tb2, 7 bab, 8 bsl, 9 ba1, 10 ba2, 11 bb1, 12 bb2
    typedef logic [12:0][NCH-1:0] fin_t;
    typedef struct {
        fin_t           stim;
        logic [NCH-1:0] tz;
        logic [NCH-1:0] cz;
    } vec_t;

    vec_t           tbl[$];
    vec_t           exp_q[$];
    int             n_vec  = 0;
    int             n_miss = 0;
    logic [NCH-1:0] exp_mode;
    logic           exp_err;

    always #5 QCK = ~QCK;

    c_frag_array #(.NCH(NCH), .DEFAULT_MODE(1'b0), .IDXW(IDXW)) dut (
        .QCK(QCK), .QRN(QRN),
        .TBS(TBS), .TAB(TAB), .TSL(TSL), .TA1(TA1), .TA2(TA2), .TB1(TB1), .TB2(TB2),
        .BAB(BAB), .BSL(BSL), .BA1(BA1), .BA2(BA2), .BB1(BB1), .BB2(BB2),
        .QEN(QEN), .CFG_VLD(CFG_VLD), .CFG_IDX(CFG_IDX), .CFG_MODE(CFG_MODE),
        .CFG_RDY(CFG_RDY), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR),
        .MODE(MODE), .TZ(TZ), .CZ(CZ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input fin_t f);
        TBS = f[0];  TAB = f[1];  TSL = f[2];  TA1 = f[3];  TA2 = f[4];  TB1 = f[5];  TB2 = f[6];
        BAB = f[7];  BSL = f[8];  BA1 = f[9];  BA2 = f[10]; BB1 = f[11]; BB2 = f[12];
    endtask

    function automatic logic half(input logic ab, input logic sl, input logic a1,
                                  input logic a2, input logic b1, input logic b2);
        case ({ab, sl})
            2'b00:   return a1;
            2'b01:   return a2;
            2'b10:   return b1;
            default: return b2;
        endcase
    endfunction

    function automatic vec_t mk(input fin_t f, input logic [NCH-1:0] m);
        vec_t v;
        logic t, b;
        v.stim = f;
        for (int i = 0; i < NCH; i++) begin
            t = half(f[1][i], f[2][i], f[3][i], f[4][i], f[5][i], f[6][i]);
            b = half(f[7][i], f[8][i], f[9][i], f[10][i], f[11][i], f[12][i]);
            v.tz[i] = t;
            v.cz[i] = m[i] ? b : (f[0][i] ? b : t);
        end
        return v;
    endfunction

    task automatic add_random(input int n);
        fin_t f;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 13; j++) f[j] = NCH'($urandom);
            tbl.push_back(mk(f, exp_mode));
        end
    endtask

    task automatic run_table(input string tag);
        vec_t e;
        int   k = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge QCK); #1;
            drive(tbl[i].stim);
            exp_q.push_back(tbl[i]);
            @(negedge QCK);
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front();
                check($sformatf("%s tz[%0d]", tag, k), TZ, e.tz);
                check($sformatf("%s cz[%0d]", tag, k), CZ, e.cz);
                k++;
            end
        end
        while (exp_q.size() > 0) begin
            @(negedge QCK);
            e = exp_q.pop_front();
            check($sformatf("%s tz[%0d]", tag, k), TZ, e.tz);
            check($sformatf("%s cz[%0d]", tag, k), CZ, e.cz);
            k++;
        end
        tbl.delete();
    endtask

    task automatic cfg_req(input logic [IDXW-1:0] idx, input logic m);
        logic [NCH-1:0] old;
        old = exp_mode;
        @(posedge QCK); #1;
        check("cfg rdy idle", CFG_RDY, 1);
        CFG_VLD = 1'b1; CFG_IDX = idx; CFG_MODE = m;
        @(posedge QCK); #1;
        CFG_VLD = 1'b0;
        if (idx < NCH) exp_mode[idx] = m;
        else exp_err = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge QCK);
            check($sformatf("cfg rdy busy%0d", c), CFG_RDY, 0);
            check($sformatf("cfg done busy%0d", c), CFG_DONE, 0);
            check($sformatf("cfg mode busy%0d", c), MODE, old);
        end
        @(negedge QCK);
        check("cfg rdy back", CFG_RDY, 1);
        check("cfg done pulse", CFG_DONE, 1);
        check("cfg mode new", MODE, exp_mode);
        check("cfg err", CFG_ERR, exp_err);
        @(negedge QCK);
        check("cfg done end", CFG_DONE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fin_t f;
        int   acc[$];
        int   dones;

        QRN = 1'b0; QEN = 1'b1; CFG_VLD = 1'b0; CFG_IDX = '0; CFG_MODE = 1'b0;
        drive('0);
        exp_mode = '0; exp_err = 1'b0;

        // reset state and CFG_RDY rising on the first edge out of reset
        repeat (3) @(negedge QCK);
        check("rst mode", MODE, 4'b0000);
        check("rst tz", TZ, 0);
        check("rst cz", CZ, 0);
        check("rst rdy", CFG_RDY, 0);
        check("rst done", CFG_DONE, 0);
        check("rst err", CFG_ERR, 0);
        @(posedge QCK); #1;
        QRN = 1'b1;
        @(negedge QCK);
        check("rdy before edge", CFG_RDY, 0);
        @(negedge QCK);
        check("rdy after edge", CFG_RDY, 1);

        // SINGLE-mode table: hand vectors first, then random ones
        f = '0; f[2] = 4'b0100; f[4] = 4'b0100;
        tbl.push_back('{stim: f, tz: 4'b0100, cz: 4'b0100});
        f[0] = 4'b0100;
        tbl.push_back('{stim: f, tz: 4'b0100, cz: 4'b0000});
        f = '0; f[1] = 4'b0001; f[5] = 4'b0001; f[0] = 4'b0010;
        f[7] = 4'b0010; f[8] = 4'b0010; f[12] = 4'b0010;
        tbl.push_back('{stim: f, tz: 4'b0001, cz: 4'b0011});
        add_random(12);
        run_table("single");

        // QEN low holds the registered outputs
        f = '0; f[3] = 4'b1111;
        @(posedge QCK); #1; drive(f);
        @(negedge QCK); @(negedge QCK);
        check("qen base tz", TZ, 4'b1111);
        @(posedge QCK); #1; QEN = 1'b0; drive('0);
        @(negedge QCK); @(negedge QCK);
        check("qen hold tz", TZ, REG ? 4'b1111 : 4'b0000);
        check("qen hold cz", CZ, REG ? 4'b1111 : 4'b0000);
        @(posedge QCK); #1; QEN = 1'b1;
        @(negedge QCK); @(negedge QCK);
        check("qen resume tz", TZ, 4'b0000);

        // channel 2 to SPLIT while all top inputs change; channel 2 output is frozen
        @(posedge QCK); #1;
        check("frz rdy idle", CFG_RDY, 1);
        CFG_VLD = 1'b1; CFG_IDX = 4'd2; CFG_MODE = 1'b1;
        @(posedge QCK); #1;
        CFG_VLD = 1'b0;
        f = '0; f[3] = 4'b1111; drive(f);
        @(negedge QCK);
        check("frz c0 tz", TZ, REG ? 4'b0000 : 4'b1111);
        check("frz c0 cz", CZ, REG ? 4'b0000 : 4'b1111);
        check("frz c0 rdy", CFG_RDY, 0);
        @(negedge QCK);
        check("frz c1 tz", TZ, REG ? 4'b1011 : 4'b1111);
        check("frz c1 cz", CZ, REG ? 4'b1011 : 4'b1111);
        check("frz c1 rdy", CFG_RDY, 0);
        @(negedge QCK);
        check("frz c2 tz", TZ, REG ? 4'b1011 : 4'b1111);
        check("frz c2 cz", CZ, 4'b1011);
        check("frz c2 done", CFG_DONE, 1);
        check("frz c2 mode", MODE, 4'b0100);
        @(negedge QCK);
        check("frz c3 tz", TZ, 4'b1111);
        check("frz c3 cz", CZ, 4'b1011);
        check("frz c3 done", CFG_DONE, 0);
        exp_mode[2] = 1'b1;

        // out-of-range index, then a legal rewrite of the current value
        cfg_req(4'd9, 1'b1);
        cfg_req(4'd2, 1'b1);
        check("err sticky", CFG_ERR, 1);

        // CFG_VLD held for 7 cycles with changing requests
        acc.delete(); dones = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge QCK); #1;
            CFG_VLD = 1'b1; CFG_IDX = (k % 2 == 0) ? 4'd0 : 4'd3; CFG_MODE = (k < 4);
            @(negedge QCK);
            if (CFG_RDY) acc.push_back(k);
            if (CFG_DONE) dones++;
        end
        @(posedge QCK); #1; CFG_VLD = 1'b0;
        repeat (3) begin
            @(negedge QCK);
            if (CFG_DONE) dones++;
            if (CFG_RDY == 1'b0) ;
        end
        check("thr accepts", acc.size(), 3);
        for (int i = 0; i < acc.size() && i < 3; i++) check($sformatf("thr accept%0d", i), acc[i], 3 * i);
        check("thr dones", dones, 3);
        exp_mode[0] = 1'b0;     // k=0 wrote 1, k=6 wrote 0 back
        exp_mode[3] = 1'b1;     // k=3
        check("thr mode", MODE, exp_mode);

        // mixed-mode table (channels 2,3 SPLIT)
        f = '0; f[3] = 4'b1111; f[0] = 4'b1111;
        tbl.push_back('{stim: f, tz: 4'b1111, cz: 4'b0000});
        f[0] = 4'b0000;
        tbl.push_back('{stim: f, tz: 4'b1111, cz: 4'b0011});
        add_random(12);
        run_table("split");

        // reset during COMMIT aborts the write
        drive('0);
        @(posedge QCK); #1;
        CFG_VLD = 1'b1; CFG_IDX = 4'd1; CFG_MODE = 1'b1;
        @(posedge QCK); #1; CFG_VLD = 1'b0;
        @(posedge QCK); #1; QRN = 1'b0;
        @(negedge QCK);
        check("abort in commit rdy", CFG_RDY, 0);
        @(negedge QCK);
        check("abort mode", MODE, 4'b0000);
        check("abort err", CFG_ERR, 0);
        check("abort done", CFG_DONE, 0);
        check("abort tz", TZ, 0);
        check("abort cz", CZ, 0);
        @(posedge QCK); #1; QRN = 1'b1;
        @(negedge QCK); @(negedge QCK);
        check("abort rdy back", CFG_RDY, 1);
        check("abort mode1", MODE[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/c_frag_array.md
# c_frag_array

Parametrised, runtime-reconfigurable array of `NCH` logic fragments; successor to the fixed two-mode C_FRAG wrapper. Each channel computes a top half and a bottom half, and is switched between SINGLE and SPLIT mode by a per-channel mode register. The mode register is written through a valid/ready configuration port, and the channel's outputs are frozen for the duration of the update. The block sits in the logic-cell model between the routing ports and the Q_FRAG flip-flops. An optional registered output stage is included.

## Interface
- `NCH`, 4, number of channels (1..16).
- `DEFAULT_MODE`, 1'b0, reset mode of every channel (0 = SINGLE, 1 = SPLIT).
- `IDXW`, 4, width of `CFG_IDX`; must satisfy 2^IDXW ≥ NCH.

Clock and reset: one clock; reset is synchronous and active-low.

Ports:
- `QCK`  in  1  clock.
- `QRN`  in  1  synchronous active-low reset.
- `TBS`  in  NCH  per-channel bottom-select.
- `TAB`, `TSL`, `TA1`, `TA2`, `TB1`, `TB2`  in  NCH each  top-half routing inputs.
- `BAB`, `BSL`, `BA1`, `BA2`, `BB1`, `BB2`  in  NCH each  bottom-half routing inputs.
- `QEN`  in  1  output-register enable (ignored without the macro).
- `CFG_VLD`  in  1  configuration request.
- `CFG_IDX`  in  IDXW  target channel.
- `CFG_MODE`  in  1  new mode.
- `CFG_RDY`  out  1  configuration port ready.
- `CFG_DONE`  out  1  one-cycle pulse marking that the new mode is visible.
- `CFG_ERR`  out  1  sticky flag: out-of-range index was accepted.
- `MODE`  out  NCH  current mode registers.
- `TZ`, `CZ`  out  NCH each  fragment outputs.

## Operation
- Half function: `H(AB,SL,A1,A2,B1,B2) = AB ? (SL ? B2 : B1) : (SL ? A2 : A1)`. This gives `TH[i]` for the top half and `BH[i]` for the bottom half.
- SINGLE mode: `TZ = TH`, `CZ = TBS ? BH : TH`.
- SPLIT mode: `TZ = TH`, `CZ = BH`; `TBS` is ignored.
- FSM states:
  - IDLE: `CFG_RDY = 1`. Goes to HOLD on `CFG_VLD & CFG_RDY`, latching `CFG_IDX` and `CFG_MODE`.
  - HOLD: goes to COMMIT unconditionally.
  - COMMIT: writes `MODE[idx]` at the end of the cycle when `idx < NCH`. When `idx ≥ NCH`, no write is made and `CFG_ERR` is set. Then goes to IDLE.
- `CFG_RDY` is registered and equals (state == IDLE); it is 0 while `QRN` = 0.
- `CFG_DONE` is high for the first IDLE cycle after COMMIT. It also pulses for out-of-range requests.
- Freeze: while state is HOLD or COMMIT, the output register of the latched channel does not update, regardless of `QEN`. All other channels update normally.
- `CFG_VLD` while `CFG_RDY` = 0 is ignored. The requester holds the request; nothing is queued.
- Rewriting the current mode value is legal. It follows the same sequence and produces the same pulse.

## Timing
- Reset values:
  - `TZ` = `CZ` = 0 (registered build).
  - `MODE` = {NCH{DEFAULT_MODE}}.
  - `CFG_RDY` = 0, `CFG_DONE` = 0, `CFG_ERR` = 0.
  - FSM state = IDLE.
- `CFG_RDY` rises on the first edge with `QRN` = 1.
- Configuration latency: accept edge to `MODE` change is 2 edges (HOLD, COMMIT). The `CFG_DONE` pulse is coincident with the new `MODE` value. Peak throughput is one request per 3 cycles.
- Registered build: `TZ`/`CZ` follow inputs 1 cycle later while `QEN` = 1, and hold while `QEN` = 0.
- The first registered output under a new mode appears one edge after `CFG_DONE`.
- `QRN` low during HOLD or COMMIT aborts the request. No partial mode write is made; all registers return to reset values.

## Configuration
- Macro `C_FRAG_ARRAY_OREG_EN` defined:
  - `TZ`/`CZ` are registered on `QCK`, with `QEN` enable and the channel freeze applied.
- Macro undefined:
  - `TZ`/`CZ` are combinational from the inputs and the `MODE` register.
  - `QEN` is unused; freeze has no effect.
  - The FSM, handshake and latency are unchanged, so configuration timing is identical in both builds.

## Structure
- Package `c_frag_pkg` holds:
  - `mode_e` (SINGLE = 0, SPLIT = 1);
  - `cfg_state_e` (IDLE, HOLD, COMMIT);
  - the half-mux function `c_frag_half`.
- One sub-module, `c_frag_lane`: a single channel holding the two halves, the mode mux and the optional output register, with inputs `mode` and `freeze`. It is instantiated `NCH` times by generate. The FSM and mode registers live in the top.

## Test plan
- Reset, NCH=4, DEFAULT_MODE=0 → `MODE`=4'b0000, `TZ`=`CZ`=0, `CFG_RDY`=0, then `CFG_RDY`=1 one cycle after `QRN` rises.
- Channel 2, SINGLE, `TAB`=0, `TSL`=1, `TA2`=1, `BH`=0, `TBS` 0→1 → `CZ[2]` goes 1 then 0 (one cycle later in the registered build).
- Request idx=2, mode=1 → `CFG_RDY` low for 2 cycles, `CFG_DONE` pulse, `MODE`=4'b0100. `CZ[2]` then follows `BH` with `TBS` ignored, and `TZ[2]` is frozen during HOLD/COMMIT while channels 0,1,3 keep updating.
- Request idx=9 → no `MODE` change, `CFG_DONE` pulses, `CFG_ERR`=1 and stays 1 until reset.
- `CFG_VLD` held high for 7 cycles with alternating requests → exactly 3 accepted (cycles 0, 3, 6).
- `QRN` dropped during COMMIT of idx=1, mode=1 → `MODE[1]` remains 0 after reset; `CFG_ERR`, `CFG_DONE` and outputs are 0.
